// File: rtl/gate_bist_pkg.sv
// Shared types and golden reference for the gate BIST sequencer.
package gate_bist_pkg;

  localparam int unsigned MAX_INPUTS = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Expected gate output for the low n bits of vec; bits at or above n are ignored.
  function automatic logic gate_ref(op_e op, logic [7:0] vec, int n);
    logic all1;
    logic any1;
    logic par;
    all1 = 1'b1;
    any1 = 1'b0;
    par  = 1'b0;
    for (int unsigned i = 0; i < MAX_INPUTS; i++) begin
      if (i < unsigned'(n)) begin
        all1 = all1 & vec[i];
        any1 = any1 | vec[i];
        par  = par ^ vec[i];
      end
    end
    case (op)
      OP_AND:  return all1;
      OP_OR:   return any1;
      OP_NAND: return ~all1;
      OP_NOR:  return ~any1;
      OP_XOR:  return par;
      OP_XNOR: return ~par;
      OP_BUF:  return vec[0];
      OP_NOT:  return ~vec[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_bist_gate_ref_model.sv
// Combinational golden model: expected GUT output for a given op and vector.
module gate_ref_model
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_INPUTS = 2
) (
  input  op_e                 op,
  input  logic [N_INPUTS-1:0] vec,
  output logic                exp
);

  logic [7:0] vec8;

  // Zero-extend the vector to the package width and evaluate the reference.
  always_comb begin
    vec8                 = '0;
    vec8[N_INPUTS-1:0]   = vec;
    exp                  = gate_ref(op, vec8, int'(N_INPUTS));
  end

endmodule

// File: rtl/gate_bist.sv
// BIST sequencer: sweeps every input vector onto a gate under test, samples
// its output after a settle delay and accumulates pass/fail results.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op_sel,
  output logic [N_INPUTS-1:0] stim,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_cnt,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_vld
);

  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS:0]   ERR_MAX     = {1'b1, {N_INPUTS{1'b0}}};

  state_e                state_q, state_d;
  logic [N_INPUTS-1:0]   stim_q, stim_d;
  logic [3:0]            settle_q, settle_d;
  op_e                   op_q, op_d;
  logic [N_INPUTS:0]     err_q, err_d;
  logic [N_INPUTS-1:0]   ffv_q, ffv_d;
  logic                  ffl_q, ffl_d;
  logic                  exp_bit;

  gate_ref_model #(.N_INPUTS(N_INPUTS)) u_ref (
    .op  (op_q),
    .vec (stim_q),
    .exp (exp_bit)
  );

  // State and result registers; reset aborts any sweep and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      stim_q   <= '0;
      settle_q <= '0;
      op_q     <= OP_AND;
      err_q    <= '0;
      ffv_q    <= '0;
      ffl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      op_q     <= op_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffl_q    <= ffl_d;
    end
  end

  // Next-state, settle/stim counters and result accumulation.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    op_d     = op_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffl_d    = ffl_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_APPLY;
          stim_d   = '0;
          settle_d = '0;
          op_d     = op_e'(op_sel);
          err_d    = '0;
          ffv_d    = '0;
          ffl_d    = 1'b0;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (dut_out != exp_bit) begin
          if (err_q != ERR_MAX) err_d = err_q + (N_INPUTS+1)'(1);
          if (!ffl_q) begin
            ffv_d = stim_q;
            ffl_d = 1'b1;
          end
        end
        // Last-vector test precedes the increment so stim never wraps.
        if (&stim_q) begin
          state_d = ST_DONE;
        end else begin
          stim_d  = stim_q + N_INPUTS'(1);
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stim           = stim_q;
  assign busy           = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (err_q == '0);
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffl_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: one 2-input/1-settle instance and one
// 3-input/3-settle instance, each driving a behavioural gate under test.
module tb_gate_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N=2, S=1
  logic       rst_a, start_a, dout_a, busy_a, done_a, pass_a, ffl_a;
  logic [2:0] op_a;
  logic [1:0] stim_a, ffv_a;
  logic [2:0] err_a;
  logic [2:0] gut_op_a;
  logic       gut_zero_a;

  // Instance B: N=3, S=3
  logic       rst_b, start_b, dout_b, busy_b, done_b, pass_b, ffl_b;
  logic [2:0] op_b;
  logic [2:0] stim_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] gut_op_b;

  gate_bist #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .op_sel(op_a), .stim(stim_a),
    .dut_out(dout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_fail_vec(ffv_a), .first_fail_vld(ffl_a)
  );

  gate_bist #(.N_INPUTS(3), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .op_sel(op_b), .stim(stim_b),
    .dut_out(dout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_fail_vec(ffv_b), .first_fail_vld(ffl_b)
  );

  function automatic logic gut2(input logic [2:0] op, input logic [1:0] v);
    case (op)
      3'd0: return &v;
      3'd1: return |v;
      3'd2: return ~&v;
      3'd3: return ~|v;
      3'd4: return ^v;
      3'd5: return ~^v;
      3'd6: return v[0];
      default: return ~v[0];
    endcase
  endfunction

  function automatic logic gut3(input logic [2:0] op, input logic [2:0] v);
    case (op)
      3'd0: return &v;
      3'd1: return |v;
      3'd2: return ~&v;
      3'd3: return ~|v;
      3'd4: return ^v;
      3'd5: return ~^v;
      3'd6: return v[0];
      default: return ~v[0];
    endcase
  endfunction

  assign dout_a = gut_zero_a ? 1'b0 : gut2(gut_op_a, stim_a);
  assign dout_b = gut3(gut_op_b, stim_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int unsigned t0;

  task automatic go_a(input logic [2:0] op);
    @(negedge clk);
    op_a    = op;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    t0      = cyc_cnt;
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [2:0] op);
    @(negedge clk);
    op_b    = op;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    t0      = cyc_cnt;
    start_b = 1'b0;
  endtask

  // Returns cycles from the accept edge until done; a timeout yields a value no check accepts.
  task automatic wait_done(input bit which_b, output int unsigned lat);
    int unsigned k;
    k = 0;
    while (!(which_b ? done_b : done_a) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = (k >= 400) ? 32'hFFFF_FFFF : cyc_cnt - t0;
  endtask

  int unsigned lat;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; op_a = 3'd0; gut_op_a = 3'd3; gut_zero_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; op_b = 3'd0; gut_op_b = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_err",  err_a, 3'd0);
    check("rst_stim", stim_a, 2'd0);
    check("rst_ffl",  ffl_a, 1'b0);
    check("rst_ffv",  ffv_a, 2'd0);
    check("rst_b_done", done_b, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // 1: NOR with a correct NOR gate
    gut_op_a = 3'd3; gut_zero_a = 1'b0;
    go_a(3'd3);
    check("t1_busy", busy_a, 1'b1);
    check("t1_stim0", stim_a, 2'd0);
    repeat (2) @(posedge clk); #1;
    check("t1_stim1", stim_a, 2'd1);
    repeat (2) @(posedge clk); #1;
    check("t1_stim2", stim_a, 2'd2);
    repeat (2) @(posedge clk); #1;
    check("t1_stim3", stim_a, 2'd3);
    wait_done(1'b0, lat);
    check("t1_lat", lat, 8);
    check("t1_pass", pass_a, 1'b1);
    check("t1_err", err_a, 3'd0);
    check("t1_ffl", ffl_a, 1'b0);
    check("t1_busy_off", busy_a, 1'b0);

    // 2: NOR with output tied low; only vector 00 mismatches
    gut_zero_a = 1'b1;
    go_a(3'd3);
    wait_done(1'b0, lat);
    check("t2_lat", lat, 8);
    check("t2_err", err_a, 3'd1);
    check("t2_ffv", ffv_a, 2'd0);
    check("t2_ffl", ffl_a, 1'b1);
    check("t2_pass", pass_a, 1'b0);

    // 3: AND expected, NAND gate; every vector mismatches
    gut_zero_a = 1'b0; gut_op_a = 3'd2;
    go_a(3'd0);
    wait_done(1'b0, lat);
    check("t3_err", err_a, 3'd4);
    check("t3_ffv", ffv_a, 2'd0);
    check("t3_ffl", ffl_a, 1'b1);
    check("t3_pass", pass_a, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("t3_hold_err", err_a, 3'd4);
    check("t3_hold_done", done_a, 1'b1);

    // 6: restart from DONE clears results; start/op_sel noise while busy ignored
    gut_op_a = 3'd3;
    go_a(3'd3);
    check("t6_clr_done", done_a, 1'b0);
    check("t6_clr_err", err_a, 3'd0);
    check("t6_clr_ffl", ffl_a, 1'b0);
    check("t6_clr_ffv", ffv_a, 2'd0);
    check("t6_busy", busy_a, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1; op_a = 3'd0;
    repeat (3) @(negedge clk);
    op_a = 3'd5;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, lat);
    check("t6_lat", lat, 8);
    check("t6_pass", pass_a, 1'b1);
    check("t6_err", err_a, 3'd0);

    // 5: reset during the third vector's APPLY
    go_a(3'd3);
    repeat (4) @(posedge clk); #1;
    check("t5_pre_stim", stim_a, 2'd2);
    check("t5_pre_busy", busy_a, 1'b1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy_a, 1'b0);
    check("t5_done", done_a, 1'b0);
    check("t5_stim", stim_a, 2'd0);
    check("t5_err", err_a, 3'd0);
    check("t5_ffl", ffl_a, 1'b0);
    check("t5_pass", pass_a, 1'b0);
    rst_a = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t5_idle_done", done_a, 1'b0);
    go_a(3'd3);
    wait_done(1'b0, lat);
    check("t5_lat", lat, 8);
    check("t5_rerun_pass", pass_a, 1'b1);

    // 4: N=3, S=3, XOR then XNOR with correct gates
    gut_op_b = 3'd4;
    go_b(3'd4);
    check("t4_busy", busy_b, 1'b1);
    wait_done(1'b1, lat);
    check("t4_xor_lat", lat, 32);
    check("t4_xor_pass", pass_b, 1'b1);
    check("t4_xor_err", err_b, 4'd0);
    gut_op_b = 3'd5;
    go_b(3'd5);
    wait_done(1'b1, lat);
    check("t4_xnor_lat", lat, 32);
    check("t4_xnor_pass", pass_b, 1'b1);

    // 4b: XNOR expected but XOR gate on N=3: every vector fails, err saturates at 8
    gut_op_b = 3'd4;
    go_b(3'd5);
    wait_done(1'b1, lat);
    check("t4_bad_err", err_b, 4'd8);
    check("t4_bad_ffv", ffv_b, 3'd0);
    check("t4_bad_pass", pass_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
